// File: rtl/pll_phase_pkg.sv
// Shared types and constants for the PLL phase calibrator.
// Includes the window-centre helper that the run search uses.
package pll_phase_pkg;

  localparam int NUM_PHASES = 16;
  localparam int PHASE_W    = 4;
  localparam int RUN_W      = PHASE_W + 1;

  typedef enum logic [2:0] {
    RST_PLL,
    WAIT_LOCK,
    SET_PHASE,
    TEST,
    PICK,
    APPLY,
    DONE,
    FAIL
  } cal_state_t;

  // Middle of a run, biased towards its start for even lengths; wraps mod 16.
  function automatic logic [PHASE_W-1:0] window_center(input logic [PHASE_W-1:0] start,
                                                       input logic [RUN_W-1:0]   len);
    logic [RUN_W-1:0] half;
    half = (len - RUN_W'(1)) >> 1;
    return start + half[PHASE_W-1:0];
  endfunction

endpackage

// File: rtl/pll_phase_cal_if.sv
// Handshake between the calibrator (master) and the external memory tester (slave).
interface pll_phase_cal_if;
  logic test_req;
  logic test_done;
  logic test_pass;

  modport master (output test_req, input test_done, input test_pass);
  modport slave  (input test_req, output test_done, output test_pass);
endinterface

// File: rtl/pll_phase_window.sv
// Serial circular longest-run search over the per-phase pass map.
// Visits positions 0..31 (mod 16), one per clock, then pulses valid.
module pll_phase_window
  import pll_phase_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_PHASES-1:0] map,
  input  logic                  start,
  output logic [PHASE_W-1:0]    center,
  output logic                  valid,
  output logic                  none
);

  localparam int POS_W = PHASE_W + 1;

  logic               busy_q, busy_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [PHASE_W-1:0] cur_start_q, cur_start_d;
  logic [RUN_W-1:0]   cur_len_q, cur_len_d;
  logic [PHASE_W-1:0] best_start_q, best_start_d;
  logic [RUN_W-1:0]   best_len_q, best_len_d;
  logic [PHASE_W-1:0] center_q, center_d;
  logic               valid_q, valid_d;
  logic               none_q, none_d;

  always_comb begin
    busy_d       = busy_q;
    pos_d        = pos_q;
    cur_start_d  = cur_start_q;
    cur_len_d    = cur_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    center_d     = center_q;
    none_d       = none_q;
    valid_d      = 1'b0;
    if (start) begin
      busy_d       = 1'b1;
      pos_d        = '0;
      cur_start_d  = '0;
      cur_len_d    = '0;
      best_start_d = '0;
      best_len_d   = '0;
    end else if (busy_q) begin
      if (map[pos_q[PHASE_W-1:0]]) begin
        if (cur_len_q == '0) cur_start_d = pos_q[PHASE_W-1:0];
        if (cur_len_q != RUN_W'(NUM_PHASES)) cur_len_d = cur_len_q + RUN_W'(1);
        // Strictly longer only, so the first-found (earliest-start) run wins ties.
        if (cur_len_d > best_len_q) begin
          best_len_d   = cur_len_d;
          best_start_d = cur_start_d;
        end
      end else begin
        cur_len_d = '0;
      end
      pos_d = pos_q + POS_W'(1);
      if (pos_q == '1) begin
        busy_d   = 1'b0;
        valid_d  = 1'b1;
        center_d = window_center(best_start_d, best_len_d);
        none_d   = (best_len_d == '0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q       <= 1'b0;
      pos_q        <= '0;
      cur_start_q  <= '0;
      cur_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
      center_q     <= '0;
      valid_q      <= 1'b0;
      none_q       <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      pos_q        <= pos_d;
      cur_start_q  <= cur_start_d;
      cur_len_q    <= cur_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
      center_q     <= center_d;
      valid_q      <= valid_d;
      none_q       <= none_d;
    end
  end

  assign center = center_q;
  assign valid  = valid_q;
  assign none   = none_q;

endmodule

// File: rtl/pll_phase_cal.sv
// PLL reset/lock sequencing plus PSDA phase sweep against an external memory
// tester; settles on the centre of the widest circular passing window.
module pll_phase_cal
  import pll_phase_pkg::*;
#(
  parameter int unsigned RESET_CYCLES  = 64,
  parameter int unsigned LOCK_TIMEOUT  = 65535,
  parameter int unsigned SETTLE_CYCLES = 32,
  parameter int unsigned MAX_RETRIES   = 3
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  pll_lock,
  output logic                  pll_reset,
  output logic [PHASE_W-1:0]    psda,
  input  logic                  cal_start,
  pll_phase_cal_if.master       tst,
  output logic [NUM_PHASES-1:0] pass_map,
  output logic                  ready,
  output logic                  fail
);

  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n;
  logic [1:0] lock_sync_q, lock_sync_d;
  logic       lock_s;

  // Reset asserts immediately, releases two clocks after resetn rises.
  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rst_sync_q <= '0;
    else         rst_sync_q <= rst_sync_d;
  end
  assign rst_n = rst_sync_q[1];

  assign lock_sync_d = {lock_sync_q[0], pll_lock};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lock_sync_q <= '0;
    else        lock_sync_q <= lock_sync_d;
  end
  assign lock_s = lock_sync_q[1];

  cal_state_t            state_q, state_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [7:0]            retry_q, retry_d;
  logic [PHASE_W-1:0]    idx_q, idx_d;
  logic [PHASE_W-1:0]    psda_q, psda_d;
  logic [NUM_PHASES-1:0] pass_map_q, pass_map_d;
  logic                  pll_reset_q, pll_reset_d;
  logic                  test_req_q, test_req_d;
  logic                  ready_q, ready_d;
  logic                  fail_q, fail_d;
  logic                  win_start_q, win_start_d;
  logic                  begin_scan;
  logic [PHASE_W-1:0]    win_center;
  logic                  win_valid;
  logic                  win_none;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 32'd1;
    retry_d     = retry_q;
    idx_d       = idx_q;
    psda_d      = psda_q;
    pass_map_d  = pass_map_q;
    test_req_d  = 1'b0;
    win_start_d = 1'b0;
    begin_scan  = 1'b0;
    if (!lock_s && (state_q inside {SET_PHASE, TEST, PICK, APPLY})) begin
      state_d = RST_PLL;
      cnt_d   = '0;
    end else begin
      case (state_q)
        RST_PLL: if (cnt_q == RESET_CYCLES - 1) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            begin_scan = 1'b1;
          end else if (cnt_q == LOCK_TIMEOUT - 1) begin
            retry_d = retry_q + 8'd1;
            cnt_d   = '0;
            state_d = (retry_d >= 8'(MAX_RETRIES)) ? FAIL : RST_PLL;
          end
        end
        SET_PHASE: if (cnt_q == SETTLE_CYCLES - 1) begin
          state_d    = TEST;
          test_req_d = 1'b1;
        end
        TEST: if (tst.test_done) begin
          pass_map_d[idx_q] = tst.test_pass;
          if (idx_q == PHASE_W'(NUM_PHASES - 1)) begin
            state_d     = PICK;
            win_start_d = 1'b1;
          end else begin
            idx_d   = idx_q + PHASE_W'(1);
            psda_d  = idx_d;
            cnt_d   = '0;
            state_d = SET_PHASE;
          end
        end
        PICK: if (win_valid) begin
          if (win_none) begin
            state_d = FAIL;
          end else begin
            state_d = APPLY;
            psda_d  = win_center;
            cnt_d   = '0;
          end
        end
        APPLY: if (cnt_q == SETTLE_CYCLES - 1) state_d = DONE;
        DONE: begin
          if (!lock_s) begin
            state_d = RST_PLL;
            retry_d = '0;
            cnt_d   = '0;
          end else if (cal_start) begin
            begin_scan = 1'b1;
          end
        end
        FAIL: if (cal_start) begin_scan = 1'b1;
        default: state_d = RST_PLL;
      endcase
    end
    if (begin_scan) begin
      state_d    = SET_PHASE;
      cnt_d      = '0;
      idx_d      = '0;
      psda_d     = '0;
      pass_map_d = '0;
    end
    pll_reset_d = (state_d == RST_PLL);
    ready_d     = (state_d == DONE);
    fail_d      = (state_d == FAIL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RST_PLL;
      cnt_q       <= '0;
      retry_q     <= '0;
      idx_q       <= '0;
      psda_q      <= '0;
      pass_map_q  <= '0;
      pll_reset_q <= 1'b1;
      test_req_q  <= 1'b0;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
      win_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      idx_q       <= idx_d;
      psda_q      <= psda_d;
      pass_map_q  <= pass_map_d;
      pll_reset_q <= pll_reset_d;
      test_req_q  <= test_req_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
      win_start_q <= win_start_d;
    end
  end

  pll_phase_window u_window (
    .clk    (clk),
    .rst_n  (rst_n),
    .map    (pass_map_q),
    .start  (win_start_q),
    .center (win_center),
    .valid  (win_valid),
    .none   (win_none)
  );

  assign pll_reset    = pll_reset_q;
  assign psda         = psda_q;
  assign tst.test_req = test_req_q;
  assign pass_map     = pass_map_q;
  assign ready        = ready_q;
  assign fail         = fail_q;

endmodule

// File: tb/tb_pll_phase_cal.sv
// Directed bench for pll_phase_cal: table of tester pass patterns with expected
// results, plus lock-timeout, lock-loss restart and async reset sequences.
module tb_pll_phase_cal;

  typedef struct {
    logic [15:0] pat;
    logic        exp_ready;
    logic        exp_fail;
    logic [3:0]  exp_psda;
    logic [15:0] exp_map;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, lock, lock_to, cal_start, cal_start_to;
  logic        pll_reset, pll_reset_to;
  logic [3:0]  psda, psda_to;
  logic [15:0] pass_map, pass_map_to;
  logic        ready, ready_to, fail, fail_to;

  pll_phase_cal_if tif ();
  pll_phase_cal_if tif_to ();

  pll_phase_cal dut (
    .clk(clk), .resetn(resetn), .pll_lock(lock), .pll_reset(pll_reset), .psda(psda),
    .cal_start(cal_start), .tst(tif), .pass_map(pass_map), .ready(ready), .fail(fail)
  );

  pll_phase_cal #(.LOCK_TIMEOUT(50)) dut_to (
    .clk(clk), .resetn(resetn), .pll_lock(lock_to), .pll_reset(pll_reset_to), .psda(psda_to),
    .cal_start(cal_start_to), .tst(tif_to), .pass_map(pass_map_to), .ready(ready_to), .fail(fail_to)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end
  endtask

  // Memory tester model: answers each request after tester_delay clocks.
  logic [15:0] pat = 16'h0000;
  int          tester_delay = 3;
  logic [3:0]  req_psda;
  initial begin
    forever begin
      @(negedge clk);
      if (tif.test_req === 1'b1) begin
        req_psda = psda;
        @(negedge clk);
        chk("req_width", {31'd0, tif.test_req}, 32'd0);
        repeat (tester_delay) @(negedge clk);
        tif.test_pass = pat[req_psda];
        tif.test_done = 1'b1;
        @(negedge clk);
        tif.test_done = 1'b0;
        tif.test_pass = 1'b0;
      end
    end
  end

  // pll_reset pulse length monitors
  int to_pulses = 0, to_run = 0;
  int to_len[8];
  int dut_pulses = 0, dut_run = 0, dut_last = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (pll_reset_to) to_run++;
        else if (to_run > 0) begin
          if (to_pulses < 8) to_len[to_pulses] = to_run;
          to_pulses++;
          to_run = 0;
        end
        if (pll_reset) dut_run++;
        else if (dut_run > 0) begin
          dut_last = dut_run;
          dut_pulses++;
          dut_run = 0;
        end
      end
    end
  end

  task automatic wait_cal(input string name);
    int k;
    for (k = 0; k < 6000 && !(ready || fail); k++) @(negedge clk);
    if (!(ready || fail)) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: calibration timeout, ready=%0b fail=%0b, expected one set", name, ready, fail);
    end
  endtask

  task automatic pulse_cal_start();
    @(negedge clk);
    cal_start = 1'b1;
    @(negedge clk);
    cal_start = 1'b0;
  endtask

  vec_t vecs[7];
  int   base;

  initial begin
    vecs[0] = '{pat:16'h0FF0, exp_ready:1'b1, exp_fail:1'b0, exp_psda:4'd7,  exp_map:16'h0FF0};
    vecs[1] = '{pat:16'hC007, exp_ready:1'b1, exp_fail:1'b0, exp_psda:4'd0,  exp_map:16'hC007};
    vecs[2] = '{pat:16'hFFFF, exp_ready:1'b1, exp_fail:1'b0, exp_psda:4'd7,  exp_map:16'hFFFF};
    vecs[3] = '{pat:16'h0000, exp_ready:1'b0, exp_fail:1'b1, exp_psda:4'd15, exp_map:16'h0000};
    vecs[4] = '{pat:16'h0E1C, exp_ready:1'b1, exp_fail:1'b0, exp_psda:4'd3,  exp_map:16'h0E1C};
    vecs[5] = '{pat:16'h8001, exp_ready:1'b1, exp_fail:1'b0, exp_psda:4'd15, exp_map:16'h8001};
    vecs[6] = '{pat:16'hFFFE, exp_ready:1'b1, exp_fail:1'b0, exp_psda:4'd8,  exp_map:16'hFFFE};

    resetn = 1'b0; lock = 1'b0; lock_to = 1'b0; cal_start = 1'b0; cal_start_to = 1'b0;
    tif.test_done = 1'b0; tif.test_pass = 1'b0;
    tif_to.test_done = 1'b0; tif_to.test_pass = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pll_reset", {31'd0, pll_reset}, 32'd1);
    chk("rst_psda", {28'd0, psda}, 32'd0);
    chk("rst_test_req", {31'd0, tif.test_req}, 32'd0);
    chk("rst_pass_map", {16'd0, pass_map}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_fail", {31'd0, fail}, 32'd0);

    resetn = 1'b1;
    repeat (100) @(negedge clk);
    lock = 1'b1;

    for (int v = 0; v < 7; v++) begin
      pat = vecs[v].pat;
      if (v > 0) begin
        pulse_cal_start();
        chk($sformatf("v%0d_restart_flags", v), {30'd0, ready, fail}, 32'd0);
      end
      wait_cal($sformatf("v%0d", v));
      chk($sformatf("v%0d_ready", v), {31'd0, ready}, {31'd0, vecs[v].exp_ready});
      chk($sformatf("v%0d_fail", v), {31'd0, fail}, {31'd0, vecs[v].exp_fail});
      chk($sformatf("v%0d_psda", v), {28'd0, psda}, {28'd0, vecs[v].exp_psda});
      chk($sformatf("v%0d_pass_map", v), {16'd0, pass_map}, {16'd0, vecs[v].exp_map});
    end

    // Lock never arrives on the short-timeout instance
    chk("to_pulses", to_pulses, 3);
    chk("to_first_len_ge64", {31'd0, (to_len[0] >= 64)}, 32'd1);
    chk("to_len2", to_len[1], 64);
    chk("to_len3", to_len[2], 64);
    chk("to_fail", {31'd0, fail_to}, 32'd1);
    chk("to_ready", {31'd0, ready_to}, 32'd0);

    // Lock loss mid-TEST at phase 6 with a slow tester whose answer lands late
    pat = 16'h0FF0;
    tester_delay = 20;
    base = dut_pulses;
    pulse_cal_start();
    for (int k = 0; k < 3000 && !(tif.test_req && psda == 4'd6); k++) @(negedge clk);
    chk("idx6_req_seen", {31'd0, (tif.test_req && psda == 4'd6)}, 32'd1);
    lock = 1'b0;
    repeat (10) @(negedge clk);
    lock = 1'b1;
    for (int k = 0; k < 300 && dut_pulses == base; k++) @(negedge clk);
    chk("relock_pulses", dut_pulses - base, 1);
    chk("relock_pulse_len", dut_last, 64);
    for (int k = 0; k < 300 && !tif.test_req; k++) @(negedge clk);
    chk("restart_req", {31'd0, tif.test_req}, 32'd1);
    chk("restart_idx", {28'd0, psda}, 32'd0);
    wait_cal("relock");
    chk("relock_ready", {31'd0, ready}, 32'd1);
    chk("relock_psda", {28'd0, psda}, 32'd7);
    chk("relock_pass_map", {16'd0, pass_map}, 32'h0FF0);

    // Reset assertion takes effect without a clock edge
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("async_pll_reset", {31'd0, pll_reset}, 32'd1);
    chk("async_ready", {31'd0, ready}, 32'd0);
    chk("async_psda", {28'd0, psda}, 32'd0);
    chk("async_pass_map", {16'd0, pass_map}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
